axi_lite_arb2: RTL and testbench

AXI_LITE_ARB2 -- requirements
Module: axi_lite_arb2

---
 rtl/axi_lite_arb2_if.sv | 51 +++++
 rtl/axi_lite_arb2.sv | 143 ++++++++++++++
 tb/tb_axi_lite_arb2.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_arb2_if.sv
// AXI4-Lite channel bundle shared by the arbiter's master and slave sides.
// master/slave: full AR/R/AW/W/B channels; rd_master/rd_slave: AR/R only.
interface axi_lite_arb2_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 64,
  parameter int DSIZE  = 8
);
  logic [AWIDTH-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [AWIDTH-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DWIDTH-1:0] wdata;
  logic [DSIZE-1:0]  wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

  modport rd_master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport rd_slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_arb2.sv
// 2-master/1-slave AXI4-Lite arbiter, one transaction in flight.
// Ports: clk, resetn (sync, active-low), m0 (read-only), m1 (rd/wr), s (slave).
module axi_lite_arb2 #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 64,
  parameter int DSIZE  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  axi_lite_arb2_if.rd_slave m0,
  axi_lite_arb2_if.slave    m1,
  axi_lite_arb2_if.master   s
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WXFER = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;

  logic [2:0] state;
  logic       owner;
  logic       last_rd;
  logic       aw_done;
  logic       w_done;

  logic [AWIDTH-1:0] ar_addr;
  logic [DWIDTH-1:0] r_data;
  logic [DSIZE-1:0]  w_strb;

  logic aw_hs;
  logic w_hs;

  assign ar_addr = owner ? m1.araddr : m0.araddr;
  assign r_data  = s.rdata;
  assign w_strb  = m1.wstrb;

  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid & s.wready;

  always_comb begin
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = r_data;
    m0.rresp   = s.rresp;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = r_data;
    m1.rresp   = s.rresp;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bresp   = s.bresp;
    s.araddr   = ar_addr;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = m1.awaddr;
    s.awvalid  = 1'b0;
    s.wdata    = m1.wdata;
    s.wstrb    = w_strb;
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    case (state)
      RADDR: begin
        s.arvalid  = owner ? m1.arvalid : m0.arvalid;
        m0.arready = ~owner & s.arready;
        m1.arready = owner & s.arready;
      end
      RDATA: begin
        s.rready  = owner ? m1.rready : m0.rready;
        m0.rvalid = ~owner & s.rvalid;
        m1.rvalid = owner & s.rvalid;
      end
      WXFER: begin
        // A channel that already handshook is masked off both ways.
        s.awvalid  = m1.awvalid & ~aw_done;
        m1.awready = s.awready & ~aw_done;
        s.wvalid   = m1.wvalid & ~w_done;
        m1.wready  = s.wready & ~w_done;
      end
      WRESP: begin
        m1.bvalid = s.bvalid;
        s.bready  = m1.bready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last_rd <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Writes win; reads alternate away from the last reader.
          if (m1.awvalid) begin
            owner <= 1'b1;
            state <= WXFER;
          end else if (m0.arvalid && m1.arvalid) begin
            owner <= ~last_rd;
            state <= RADDR;
          end else if (m0.arvalid) begin
            owner <= 1'b0;
            state <= RADDR;
          end else if (m1.arvalid) begin
            owner <= 1'b1;
            state <= RADDR;
          end
        end
        RADDR: begin
          if (s.arvalid && s.arready)
            state <= RDATA;
        end
        RDATA: begin
          if (s.rvalid && s.rready) begin
            last_rd <= owner;
            state   <= IDLE;
          end
        end
        WXFER: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WRESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: begin
          if (s.bvalid && s.bready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: per-cycle handshake vector table
// plus hand-written read, write, priority and reset sequences.
module tb_axi_lite_arb2;

  logic clk;
  logic resetn;

  axi_lite_arb2_if #(.AWIDTH(32), .DWIDTH(64), .DSIZE(8)) m0_if ();
  axi_lite_arb2_if #(.AWIDTH(32), .DWIDTH(64), .DSIZE(8)) m1_if ();
  axi_lite_arb2_if #(.AWIDTH(32), .DWIDTH(64), .DSIZE(8)) s_if ();

  axi_lite_arb2 #(.AWIDTH(32), .DWIDTH(64), .DSIZE(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // in : {m0_arv,m1_arv,m1_awv,m1_wv, m0_rr,m1_rr,m1_br,s_arr,
  //       s_rv,s_awr,s_wr,s_bv}
  // exp: {m0_arr,m0_rv,m1_arr,m1_rv, m1_awr,m1_wr,m1_bv,s_arv,
  //       s_rr,s_awv,s_wv,s_br}
  typedef struct {
    logic [11:0] in;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[18];

  function automatic logic [11:0] outs();
    return {m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid,
            m1_if.awready, m1_if.wready, m1_if.bvalid, s_if.arvalid,
            s_if.rready, s_if.awvalid, s_if.wvalid, s_if.bready};
  endfunction

  task automatic apply(input logic [11:0] v);
    {m0_if.arvalid, m1_if.arvalid, m1_if.awvalid, m1_if.wvalid,
     m0_if.rready, m1_if.rready, m1_if.bready, s_if.arready,
     s_if.rvalid, s_if.awready, s_if.wready, s_if.bvalid} = v;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    apply(12'h000);
    m0_if.araddr = 32'h8000_0000;
    m1_if.araddr = 32'h8000_0100;
    m1_if.awaddr = 32'h0;
    m1_if.wdata  = 64'h0;
    m1_if.wstrb  = 8'h0;
    s_if.rdata   = 64'h0;
    s_if.rresp   = 2'b00;
    s_if.bresp   = 2'b00;
  endtask

  task automatic do_reset(input string nm);
    clear();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    chk(nm, {52'h0, outs()}, 64'h0);
  endtask

  // Starts in IDLE with the owner's arvalid already raised.
  task automatic rd_phase(input string nm, input bit own,
                          input logic [31:0] addr,
                          input logic [63:0] data);
    step();
    s_if.arready = 1'b1;
    #1;
    chk({nm, "_arready"}, own ? m1_if.arready : m0_if.arready, 1);
    chk({nm, "_other_arready"},
        own ? m0_if.arready : m1_if.arready, 0);
    chk({nm, "_araddr"}, s_if.araddr, addr);
    step();
    if (own) m1_if.arvalid = 1'b0;
    else     m0_if.arvalid = 1'b0;
    s_if.arready = 1'b0;
    s_if.rvalid  = 1'b1;
    s_if.rdata   = data;
    if (own) m1_if.rready = 1'b1;
    else     m0_if.rready = 1'b1;
    #1;
    chk({nm, "_rvalid"}, own ? m1_if.rvalid : m0_if.rvalid, 1);
    chk({nm, "_rdata"}, own ? m1_if.rdata : m0_if.rdata, data);
    chk({nm, "_other_rvalid"},
        own ? m0_if.rvalid : m1_if.rvalid, 0);
    step();
    s_if.rvalid  = 1'b0;
    m0_if.rready = 1'b0;
    m1_if.rready = 1'b0;
  endtask

  initial begin
    vt[0]  = '{12'b1000_0001_0000, 12'b0000_0000_0000, "idle_m0_req"};
    vt[1]  = '{12'b1000_0001_0000, 12'b1000_0001_0000, "raddr_m0"};
    vt[2]  = '{12'b0000_0000_1000, 12'b0100_0000_0000, "rdata_m0_stall"};
    vt[3]  = '{12'b0000_1000_1000, 12'b0100_0000_1000, "rdata_m0_hs"};
    vt[4]  = '{12'b0000_0000_0000, 12'b0000_0000_0000, "idle_quiet"};
    vt[5]  = '{12'b1100_0000_0000, 12'b0000_0000_0000, "idle_both"};
    vt[6]  = '{12'b1100_0000_0000, 12'b0000_0001_0000, "raddr_m1_wait"};
    vt[7]  = '{12'b1100_0001_0000, 12'b0010_0001_0000, "raddr_m1_hs"};
    vt[8]  = '{12'b1000_0100_1000, 12'b0001_0000_1000, "rdata_m1_hs"};
    vt[9]  = '{12'b1011_0000_0110, 12'b0000_0000_0000, "idle_wr_prio"};
    vt[10] = '{12'b1010_0000_0110, 12'b0000_1100_0100, "wxfer_aw"};
    vt[11] = '{12'b1010_0000_0110, 12'b0000_0100_0000, "wxfer_aw_mask"};
    vt[12] = '{12'b1001_0000_0010, 12'b0000_0100_0010, "wxfer_w"};
    vt[13] = '{12'b1000_0010_0000, 12'b0000_0000_0001, "wresp_wait"};
    vt[14] = '{12'b1000_0010_0001, 12'b0000_0010_0001, "wresp_hs"};
    vt[15] = '{12'b1000_0000_0000, 12'b0000_0000_0000, "idle_m0_after_wr"};
    vt[16] = '{12'b1000_0001_0000, 12'b1000_0001_0000, "raddr_m0_2"};
    vt[17] = '{12'b0000_1000_1000, 12'b0100_0000_1000, "rdata_m0_2"};

    clear();
    resetn = 1'b0;
    step();
    step();
    do_reset("reset_outs");

    for (int i = 0; i < 18; i++) begin
      apply(vt[i].in);
      #1;
      chk(vt[i].nm, {52'h0, outs()}, {52'h0, vt[i].exp});
      step();
    end

    // single m0 read with data
    do_reset("reset_a");
    m0_if.arvalid = 1'b1;
    rd_phase("m0_read", 1'b0, 32'h8000_0000, 64'h1122_3344_5566_7788);
    #1;
    chk("m0_read_idle", {52'h0, outs()}, 64'h0);

    // simultaneous reads alternate, m0 first out of reset
    do_reset("reset_b");
    m0_if.arvalid = 1'b1;
    m1_if.arvalid = 1'b1;
    rd_phase("rr1_m0", 1'b0, 32'h8000_0000, 64'hA0);
    m0_if.arvalid = 1'b1;
    rd_phase("rr2_m1", 1'b1, 32'h8000_0100, 64'hA1);
    m1_if.arvalid = 1'b1;
    rd_phase("rr3_m0", 1'b0, 32'h8000_0000, 64'hA2);
    m1_if.arvalid = 1'b0;

    // write, AW and W together
    do_reset("reset_c");
    m1_if.awvalid = 1'b1;
    m1_if.awaddr  = 32'h8000_0010;
    m1_if.wvalid  = 1'b1;
    m1_if.wdata   = 64'hDEAD_BEEF;
    m1_if.wstrb   = 8'h0F;
    step();
    s_if.awready = 1'b1;
    s_if.wready  = 1'b1;
    #1;
    chk("wr_awvalid", s_if.awvalid, 1);
    chk("wr_wvalid", s_if.wvalid, 1);
    chk("wr_awaddr", s_if.awaddr, 32'h8000_0010);
    chk("wr_wdata", s_if.wdata, 64'hDEAD_BEEF);
    chk("wr_wstrb", s_if.wstrb, 8'h0F);
    step();
    m1_if.awvalid = 1'b0;
    m1_if.wvalid  = 1'b0;
    s_if.awready  = 1'b0;
    s_if.wready   = 1'b0;
    m1_if.bready  = 1'b1;
    #1;
    chk("wr_bvalid_early", m1_if.bvalid, 0);
    step();
    s_if.bvalid = 1'b1;
    s_if.bresp  = 2'b00;
    #1;
    chk("wr_bvalid", m1_if.bvalid, 1);
    chk("wr_bresp", m1_if.bresp, 2'b00);
    chk("wr_bready", s_if.bready, 1);
    step();
    s_if.bvalid  = 1'b0;
    m1_if.bready = 1'b0;
    #1;
    chk("wr_idle", {52'h0, outs()}, 64'h0);

    // AW at cycle n, W at n+3
    do_reset("reset_d");
    m1_if.awvalid = 1'b1;
    m1_if.bready  = 1'b1;
    s_if.bvalid   = 1'b1;
    step();
    s_if.awready = 1'b1;
    #1;
    chk("split_awvalid", s_if.awvalid, 1);
    chk("split_wvalid", s_if.wvalid, 0);
    step();
    #1;
    chk("split_aw_mask1", {s_if.awvalid, m1_if.awready}, 0);
    chk("split_nobv1", m1_if.bvalid, 0);
    step();
    #1;
    chk("split_aw_mask2", {s_if.awvalid, m1_if.awready}, 0);
    chk("split_nobv2", m1_if.bvalid, 0);
    step();
    m1_if.wvalid = 1'b1;
    s_if.wready  = 1'b1;
    #1;
    chk("split_w", {s_if.wvalid, m1_if.wready}, 2'b11);
    chk("split_nobv3", m1_if.bvalid, 0);
    step();
    m1_if.awvalid = 1'b0;
    m1_if.wvalid  = 1'b0;
    s_if.awready  = 1'b0;
    s_if.wready   = 1'b0;
    #1;
    chk("split_wresp", m1_if.bvalid, 1);
    step();
    s_if.bvalid  = 1'b0;
    m1_if.bready = 1'b0;
    #1;
    chk("split_idle", {52'h0, outs()}, 64'h0);

    // write beats pending reads, then m0, then m1
    do_reset("reset_e");
    m0_if.arvalid = 1'b1;
    m1_if.arvalid = 1'b1;
    m1_if.awvalid = 1'b1;
    m1_if.wvalid  = 1'b1;
    step();
    s_if.awready = 1'b1;
    s_if.wready  = 1'b1;
    #1;
    chk("prio_awvalid", s_if.awvalid, 1);
    chk("prio_no_ar", s_if.arvalid, 0);
    step();
    m1_if.awvalid = 1'b0;
    m1_if.wvalid  = 1'b0;
    s_if.awready  = 1'b0;
    s_if.wready   = 1'b0;
    s_if.bvalid   = 1'b1;
    m1_if.bready  = 1'b1;
    #1;
    chk("prio_bvalid", m1_if.bvalid, 1);
    step();
    s_if.bvalid  = 1'b0;
    m1_if.bready = 1'b0;
    rd_phase("prio_m0", 1'b0, 32'h8000_0000, 64'hB0);
    rd_phase("prio_m1", 1'b1, 32'h8000_0100, 64'hB1);

    // reset in RDATA abandons the read
    do_reset("reset_f");
    m1_if.arvalid = 1'b1;
    step();
    s_if.arready = 1'b1;
    step();
    m1_if.arvalid = 1'b0;
    s_if.arready  = 1'b0;
    s_if.rvalid   = 1'b1;
    #1;
    chk("rst_mid_rvalid", m1_if.rvalid, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    chk("rst_mid_outs", {52'h0, outs()}, 64'h0);
    s_if.rvalid   = 1'b0;
    m0_if.arvalid = 1'b1;
    rd_phase("rst_after_m0", 1'b0, 32'h8000_0000, 64'hC0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
